// File: rtl/jedro_1_shift_pkg.sv
// jedro_1 sequential shifter: shared types and op legality.
// JEDRO_1_SHIFT_ROT_EN makes ROL/ROR legal ops.
package jedro_1_shift_pkg;

  typedef enum logic [2:0] {
    OP_SLL = 3'b000,
    OP_SRL = 3'b001,
    OP_SRA = 3'b011,
    OP_ROL = 3'b100,
    OP_ROR = 3'b101
  } shift_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } shift_state_e;

  function automatic logic is_legal_op(input logic [2:0] op);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_SLL, OP_SRL, OP_SRA: ok = 1'b1;
`ifdef JEDRO_1_SHIFT_ROT_EN
      OP_ROL, OP_ROR: ok = 1'b1;
`endif
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/jedro_1_shift_step.sv
// jedro_1 shifter single step: shifts by 0..STEP bits for one op.
// Rotate arms exist only with JEDRO_1_SHIFT_ROT_EN.
module jedro_1_shift_step
  import jedro_1_shift_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int STEP       = 1,
  parameter int AMT_WIDTH  = $clog2(STEP + 1)
) (
  input  logic [2:0]            op_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [AMT_WIDTH-1:0]  amt_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic w_sll;
  logic w_srl;
  logic w_sra;
  logic w_rol;
  logic w_ror;

  assign w_sll = (op_i == OP_SLL);
  assign w_srl = (op_i == OP_SRL);
  assign w_sra = (op_i == OP_SRA);
  assign w_rol = (op_i == OP_ROL);
  assign w_ror = (op_i == OP_ROR);

  // One step of the selected shift; SRA replicates the current MSB,
  // which always equals the operand's original MSB.
  always_comb begin
    data_o = data_i;
    unique case (1'b1)
      w_sll: data_o = data_i << amt_i;
      w_srl: data_o = data_i >> amt_i;
      w_sra: data_o = $signed(data_i) >>> amt_i;
`ifdef JEDRO_1_SHIFT_ROT_EN
      w_rol: data_o = (data_i << amt_i)
                    | (data_i >> (DATA_WIDTH - int'(amt_i)));
      w_ror: data_o = (data_i >> amt_i)
                    | (data_i << (DATA_WIDTH - int'(amt_i)));
`else
      w_rol: data_o = data_i;
      w_ror: data_o = data_i;
`endif
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/jedro_1_seq_shifter.sv
// jedro_1 multi-cycle shift unit (SLL/SRL/SRA, STEP bits per cycle).
// Define JEDRO_1_SHIFT_ROT_EN to add ROL/ROR.
module jedro_1_seq_shifter
  import jedro_1_shift_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH),
  parameter int STEP        = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [2:0]             op_i,
  input  logic [DATA_WIDTH-1:0]  data_i,
  input  logic [SHAMT_WIDTH-1:0] shamt_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [DATA_WIDTH-1:0]  result_o,
  output logic                   busy_o,
  output logic                   illegal_op_o
);

  localparam int AW = $clog2(STEP + 1);
  localparam logic [SHAMT_WIDTH:0] STEP_W = (SHAMT_WIDTH + 1)'(STEP);

  shift_state_e r_state;
  shift_state_e w_next;

  logic [DATA_WIDTH-1:0]  r_data;
  logic [2:0]             r_op;
  logic [SHAMT_WIDTH-1:0] r_rem;
  logic                   r_ill;

  logic                   w_hs;
  logic                   w_legal;
  logic                   w_last;
  logic [SHAMT_WIDTH:0]   w_rem_x;
  logic [SHAMT_WIDTH:0]   w_k;
  logic [AW-1:0]          w_amt;
  logic [DATA_WIDTH-1:0]  w_step;

  assign w_hs    = valid_i & ready_o;
  assign w_legal = is_legal_op(op_i);
  assign w_rem_x = {1'b0, r_rem};
  assign w_k     = (w_rem_x < STEP_W) ? w_rem_x : STEP_W;
  assign w_last  = (w_rem_x <= STEP_W);
  assign w_amt   = AW'(w_k);

  jedro_1_shift_step #(
    .DATA_WIDTH (DATA_WIDTH),
    .STEP       (STEP),
    .AMT_WIDTH  (AW)
  ) u_step (
    .op_i   (r_op),
    .data_i (r_data),
    .amt_i  (w_amt),
    .data_o (w_step)
  );

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next state: zero shifts skip straight to DONE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_hs && w_legal) begin
          w_next = (shamt_i == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: if (w_last) w_next = S_DONE;
      S_DONE:  if (ready_i) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    ready_o = 1'b0;
    valid_o = 1'b0;
    busy_o  = 1'b0;
    case (r_state)
      S_IDLE:  ready_o = 1'b1;
      S_SHIFT: busy_o  = 1'b1;
      S_DONE: begin
        valid_o = 1'b1;
        busy_o  = 1'b1;
      end
      default: ready_o = 1'b0;
    endcase
  end

  // Working register, remaining count and the illegal-op pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_data <= '0;
      r_op   <= OP_SLL;
      r_rem  <= '0;
      r_ill  <= 1'b0;
    end else begin
      r_ill <= w_hs & ~w_legal;
      if (w_hs && w_legal) begin
        r_data <= data_i;
        r_op   <= op_i;
        r_rem  <= shamt_i;
      end else if (r_state == S_SHIFT) begin
        r_data <= w_step;
        r_rem  <= r_rem - SHAMT_WIDTH'(w_k);
      end
    end
  end

  assign result_o     = r_data;
  assign illegal_op_o = r_ill;

endmodule

// File: tb/tb_jedro_1_seq_shifter.sv
// Bench for jedro_1_seq_shifter: STEP=1 and STEP=4 instances share stimulus.
// Honours JEDRO_1_SHIFT_ROT_EN for the rotate cases.
`timescale 1ns/1ps
module tb_jedro_1_seq_shifter;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic        ready_i;
  logic [2:0]  op_i;
  logic [31:0] data_i;
  logic [4:0]  shamt_i;

  logic [1:0]       rdy;
  logic [1:0]       vld;
  logic [1:0]       bsy;
  logic [1:0]       ill;
  logic [1:0][31:0] res;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jedro_1_seq_shifter #(.DATA_WIDTH(32), .STEP(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(rdy[0]),
    .op_i(op_i), .data_i(data_i), .shamt_i(shamt_i), .valid_o(vld[0]),
    .ready_i(ready_i), .result_o(res[0]), .busy_o(bsy[0]),
    .illegal_op_o(ill[0])
  );

  jedro_1_seq_shifter #(.DATA_WIDTH(32), .STEP(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(rdy[1]),
    .op_i(op_i), .data_i(data_i), .shamt_i(shamt_i), .valid_o(vld[1]),
    .ready_i(ready_i), .result_o(res[1]), .busy_o(bsy[1]),
    .illegal_op_o(ill[1])
  );

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  // Reference: whole-operation result from plain arithmetic.
  function automatic logic [31:0] ref_op(input logic [2:0] op,
                                         input logic [31:0] d,
                                         input int s);
    logic [31:0] r;
    r = d;
    case (op)
      3'b000: r = d << s;
      3'b001: r = d >> s;
      3'b011: r = $signed(d) >>> s;
      3'b100: r = (s == 0) ? d : ((d << s) | (d >> (32 - s)));
      3'b101: r = (s == 0) ? d : ((d >> s) | (d << (32 - s)));
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic bit legal(input logic [2:0] op);
`ifdef JEDRO_1_SHIFT_ROT_EN
    return op inside {3'b000, 3'b001, 3'b011, 3'b100, 3'b101};
`else
    return op inside {3'b000, 3'b001, 3'b011};
`endif
  endfunction

  // Transaction-level model: result due ceil(shamt/STEP)+1 cycles
  // after the accepting cycle, held until consumed.
  int          cyc = 0;
  int          steps [2] = '{1, 4};
  bit          m_busy [2];
  int          m_due [2];
  logic [31:0] m_res [2];
  bit          m_ill [2];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc = 0;
      for (int k = 0; k < 2; k++) begin
        m_busy[k] = 1'b0;
        m_ill[k]  = 1'b0;
        m_due[k]  = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_ill[k] = 1'b0;
        if (!m_busy[k]) begin
          if (valid_i) begin
            if (legal(op_i)) begin
              m_busy[k] = 1'b1;
              m_res[k]  = ref_op(op_i, data_i, int'(shamt_i));
              m_due[k]  = cyc + (int'(shamt_i) + steps[k] - 1) / steps[k] + 1;
            end else begin
              m_ill[k] = 1'b1;
            end
          end
        end else if (cyc >= m_due[k] && ready_i) begin
          m_busy[k] = 1'b0;
        end
      end
      cyc++;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit ev;
      ev = m_busy[k] && (cyc >= m_due[k]);
      chk($sformatf("valid_o[%0d]", k), 32'(vld[k]), 32'(ev));
      chk($sformatf("ready_o[%0d]", k), 32'(rdy[k]), 32'(!m_busy[k]));
      chk($sformatf("busy_o[%0d]", k), 32'(bsy[k]), 32'(m_busy[k]));
      chk($sformatf("illegal_op_o[%0d]", k), 32'(ill[k]), 32'(m_ill[k]));
      if (ev) chk($sformatf("result_o[%0d]", k), res[k], m_res[k]);
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (rdy != 2'b11 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", 32'(rdy), 32'd3);
  endtask

  task automatic run(input logic [2:0] op, input logic [31:0] d,
                     input logic [4:0] s, input logic [31:0] e,
                     input int l1, input int l4);
    int          lat [2];
    logic [31:0] got [2];
    int          n;
    lat = '{0, 0};
    got = '{32'h0, 32'h0};
    wait_idle();
    valid_i = 1'b1;
    op_i    = op;
    data_i  = d;
    shamt_i = s;
    @(negedge clk);
    valid_i = 1'b0;
    n = 1;
    while ((lat[0] == 0 || lat[1] == 0) && n < 100) begin
      for (int k = 0; k < 2; k++) begin
        if (lat[k] == 0 && vld[k]) begin
          lat[k] = n;
          got[k] = res[k];
        end
      end
      if (lat[0] == 0 || lat[1] == 0) begin
        @(negedge clk);
        n++;
      end
    end
    chk($sformatf("lat_step1 op%0d d%08h s%0d", op, d, s), 32'(lat[0]), 32'(l1));
    chk($sformatf("lat_step4 op%0d d%08h s%0d", op, d, s), 32'(lat[1]), 32'(l4));
    chk($sformatf("res_step1 op%0d d%08h s%0d", op, d, s), got[0], e);
    chk($sformatf("res_step4 op%0d d%08h s%0d", op, d, s), got[1], e);
  endtask

  task automatic illegal(input logic [2:0] op);
    wait_idle();
    valid_i = 1'b1;
    op_i    = op;
    data_i  = 32'h8000_0001;
    shamt_i = 5'd1;
    @(negedge clk);
    valid_i = 1'b0;
    chk($sformatf("ill_pulse op%0d", op), 32'(ill), 32'd3);
    chk($sformatf("ill_valid op%0d", op), 32'(vld), 32'd0);
    chk($sformatf("ill_ready op%0d", op), 32'(rdy), 32'd3);
    @(negedge clk);
    chk($sformatf("ill_clear op%0d", op), 32'(ill), 32'd0);
    chk($sformatf("ill_valid2 op%0d", op), 32'(vld), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst     = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    op_i    = 3'b000;
    data_i  = '0;
    shamt_i = '0;
    @(negedge clk);
    chk("rst_ready", 32'(rdy), 32'd3);
    chk("rst_valid", 32'(vld), 32'd0);
    chk("rst_busy", 32'(bsy), 32'd0);
    chk("rst_ill", 32'(ill), 32'd0);
    chk("rst_res1", res[0], 32'h0);
    chk("rst_res4", res[1], 32'h0);
    rst = 1'b0;
    @(negedge clk);

    run(3'b000, 32'h0000_0001, 5'd1, 32'h0000_0002, 2, 2);
    run(3'b000, 32'h0000_0002, 5'd2, 32'h0000_0008, 3, 2);
    run(3'b000, 32'h0000_0008, 5'd3, 32'h0000_0040, 4, 2);
    run(3'b011, 32'h8000_0000, 5'd4, 32'hF800_0000, 5, 2);
    run(3'b001, 32'h8000_0000, 5'd4, 32'h0800_0000, 5, 2);
    run(3'b000, 32'h0000_0001, 5'd31, 32'h8000_0000, 32, 9);
    run(3'b000, 32'h0000_0001, 5'd0, 32'h0000_0001, 1, 1);
    run(3'b011, 32'h8000_0010, 5'd31, 32'hFFFF_FFFF, 32, 9);
    run(3'b001, 32'hF000_000F, 5'd5, 32'h0780_0000, 6, 3);

    // Back-pressure: hold the result for ten cycles.
    wait_idle();
    ready_i = 1'b0;
    valid_i = 1'b1;
    op_i    = 3'b000;
    data_i  = 32'd5;
    shamt_i = 5'd3;
    @(negedge clk);
    valid_i = 1'b0;
    n = 0;
    while (vld != 2'b11 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_reach", 32'(vld), 32'd3);
    repeat (10) begin
      @(negedge clk);
      chk("bp_res1", res[0], 32'd40);
      chk("bp_res4", res[1], 32'd40);
      chk("bp_valid", 32'(vld), 32'd3);
      chk("bp_ready", 32'(rdy), 32'd0);
    end
    ready_i = 1'b1;
    @(negedge clk);
    chk("bp_ready_after", 32'(rdy), 32'd3);
    chk("bp_valid_after", 32'(vld), 32'd0);

    illegal(3'b010);
    illegal(3'b110);
`ifdef JEDRO_1_SHIFT_ROT_EN
    run(3'b100, 32'h8000_0001, 5'd1, 32'h0000_0003, 2, 2);
    run(3'b101, 32'h0000_0003, 5'd1, 32'h8000_0001, 2, 2);
    run(3'b100, 32'h1234_5678, 5'd8, 32'h3456_7812, 9, 3);
`else
    illegal(3'b100);
    illegal(3'b101);
`endif

    // Reset in the middle of a long shift.
    wait_idle();
    valid_i = 1'b1;
    op_i    = 3'b000;
    data_i  = 32'd1;
    shamt_i = 5'd20;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_busy", 32'(bsy), 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("arst_ready", 32'(rdy), 32'd3);
    chk("arst_valid", 32'(vld), 32'd0);
    chk("arst_busy", 32'(bsy), 32'd0);
    chk("arst_ill", 32'(ill), 32'd0);
    chk("arst_res1", res[0], 32'h0);
    chk("arst_res4", res[1], 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run(3'b000, 32'h0000_0003, 5'd2, 32'h0000_000C, 3, 2);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
